// File: rtl/riscv_pkg.sv
// Shared core definitions: opcode constants, fetch FSM states, next-PC selects.
package riscv_pkg;

   localparam int INSTR_W = 32;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_B = 7'b1100011;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_TGT  = 2'd2
   } pc_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   import riscv_pkg::*;

   logic               imem_req_o;
   logic [XLEN-1:0]    imem_addr_o;
   logic               imem_ack_i;
   logic [INSTR_W-1:0] imem_rdata_i;

   modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i);
   modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: hold, sequential +4, or word-aligned target.
module pc_next
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] target,
   input  pc_sel_t         sel,
   output logic [XLEN-1:0] nxt
);

   // +4 wraps naturally at 2^XLEN; target low bits are dropped
   always_comb begin
      nxt = pc;
      unique case (sel)
         PC_INC:  nxt = pc + XLEN'(4);
         PC_TGT:  nxt = {target[XLEN-1:2], 2'b00};
         default: nxt = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem, presents one word at a time.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   fetch_unit_if.master       imem,
   input  logic               stall_i,
   input  logic               branch_taken_i,
   input  logic [XLEN-1:0]    branch_target_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [6:0]         opcode_o,
   output logic [XLEN-1:0]    pc_o,
   output logic               instr_valid_o,
   output logic [CNT_W-1:0]   fetch_count_o
);

   fetch_state_t       state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d, tgt_q, tgt_src;
   logic               pend_q;
   logic [INSTR_W-1:0] instr_q;
   logic [XLEN-1:0]    pc_out_q;
   logic               valid_q;
   logic [CNT_W-1:0]   cnt_q;
   pc_sel_t            pc_sel;
   logic               capture, consume, drop, pend_set, pend_clr;

   // A branch in the current cycle beats any target captured earlier
   assign tgt_src = branch_taken_i ? branch_target_i : tgt_q;

   pc_next #(.XLEN(XLEN)) u_pc_next (
      .pc     (pc_q),
      .target (tgt_src),
      .sel    (pc_sel),
      .nxt    (pc_d)
   );

   // Next state and per-cycle actions; acks outside FETCH are ignored
   always_comb begin
      state_d  = state_q;
      pc_sel   = PC_HOLD;
      capture  = 1'b0;
      consume  = 1'b0;
      drop     = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (imem.imem_ack_i) begin
               // ack closes the transaction, so the address may move next cycle
               pend_clr = 1'b1;
               if (branch_taken_i || pend_q) begin
                  pc_sel = PC_TGT;
               end else begin
                  capture = 1'b1;
                  state_d = VALID;
               end
            end else if (branch_taken_i) begin
               // address must stay put while req is outstanding
               pend_set = 1'b1;
            end
         end
         VALID: begin
            if (branch_taken_i) begin
               pc_sel  = PC_TGT;
               drop    = 1'b1;
               state_d = FETCH;
            end else if (!stall_i) begin
               pc_sel  = PC_INC;
               consume = 1'b1;
               drop    = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State, PC, pending redirect, presented instruction and counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         tgt_q    <= '0;
         pend_q   <= 1'b0;
         instr_q  <= '0;
         pc_out_q <= RESET_PC;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (pend_set) begin
            pend_q <= 1'b1;
            tgt_q  <= {branch_target_i[XLEN-1:2], 2'b00};
         end else if (pend_clr) begin
            pend_q <= 1'b0;
         end
         if (capture) begin
            instr_q  <= imem.imem_rdata_i;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
         end else if (drop) begin
            valid_q <= 1'b0;
         end
         if (consume) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign imem.imem_req_o  = (state_q == FETCH);
   assign imem.imem_addr_o = pc_q;
   assign instr_o          = instr_q;
   assign opcode_o         = instr_q[6:0];
   assign pc_o             = pc_out_q;
   assign instr_valid_o    = valid_q;
   assign fetch_count_o    = cnt_q;

endmodule
